dram_arbiter: RTL and testbench

- Shares the single-port data RAM between two requesters: the ARM core's data port (requester 0) and an auxiliary master such as a DMA or display reader (requester 1).
- Sits between the masters and the dram instance in the processor top level.
- Uses a req/ack handshake, a fixed 4-state sequence per access and round-robin arbitration, so neither requester can starve the other.

---
 rtl/dram_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_dram_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// ---------------------------------------------------------------------------
// dram_arbiter
//
// Shares the single-port data RAM between two masters: the core's data port
// (requester 0) and an auxiliary master such as DMA or a display reader
// (requester 1). Each access walks a fixed IDLE -> ISSUE -> CAPTURE -> DONE
// sequence. Arbitration is round-robin on contention, so neither master can
// starve the other.
//
// Ports
//   clk                 system clock, rising edge
//   reset               synchronous reset, active low
//   rN_req              access request, held until rN_ack
//   rN_we               1 = write, 0 = read
//   rN_addr / rN_wdata  access address / write data, latched at grant
//   rN_rdata            read data, valid while rN_ack is high, held afterwards
//   rN_ack              one-cycle completion pulse
//   mem_addr/mem_wdata  RAM address / write data (registered)
//   mem_we              RAM write strobe, high only during ISSUE
//   mem_rdata           RAM read data, one cycle after the address
// ---------------------------------------------------------------------------
module dram_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic [DW-1:0] r0_rdata,
    output logic          r0_ack,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic [DW-1:0] r1_rdata,
    output logic          r1_ack,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic          prio_reg;      // requester that wins the next contended IDLE sample
    logic          gnt_reg;       // requester owning the access in flight
    logic          we_reg;        // latched direction of the access in flight
    logic [AW-1:0] mem_addr_reg;  // doubles as the latched address
    logic [DW-1:0] mem_wdata_reg; // doubles as the latched write data
    logic          mem_we_reg;

    logic          grant;
    logic          gnt_pick;

    // Requester inputs gathered into indexable form so the grant mux is a
    // simple index by the chosen requester.
    logic [1:0]    req_vec;
    logic [1:0]    we_vec;
    logic [AW-1:0] addr_vec  [2];
    logic [DW-1:0] wdata_vec [2];

    assign req_vec      = {r1_req, r0_req};
    assign we_vec       = {r1_we, r0_we};
    assign addr_vec[0]  = r0_addr;
    assign addr_vec[1]  = r1_addr;
    assign wdata_vec[0] = r0_wdata;
    assign wdata_vec[1] = r1_wdata;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and grant decision
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        grant      = 1'b0;
        gnt_pick   = prio_reg;
        case (state_reg)
            IDLE: begin
                if (req_vec[0] && req_vec[1]) begin
                    grant    = 1'b1;
                    gnt_pick = prio_reg;
                end else if (req_vec[0]) begin
                    grant    = 1'b1;
                    gnt_pick = 1'b0;
                end else if (req_vec[1]) begin
                    grant    = 1'b1;
                    gnt_pick = 1'b1;
                end
                if (grant) begin
                    state_next = ISSUE;
                end
            end
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Grant latch and RAM port. The RAM-side registers are loaded on the
    // grant edge so that ISSUE sees the access on the port; mem_we falls
    // again on the following edge, giving exactly one write-strobe cycle.
    // The address stays on the port until the next grant.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            prio_reg      <= 1'b0;
            gnt_reg       <= 1'b0;
            we_reg        <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_we_reg    <= 1'b0;
        end else begin
            mem_we_reg <= 1'b0;
            if (grant) begin
                gnt_reg       <= gnt_pick;
                we_reg        <= we_vec[gnt_pick];
                prio_reg      <= ~gnt_pick;
                mem_addr_reg  <= addr_vec[gnt_pick];
                mem_wdata_reg <= wdata_vec[gnt_pick];
                mem_we_reg    <= we_vec[gnt_pick];
            end
        end
    end

    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_we    = mem_we_reg;

    // -----------------------------------------------------------------------
    // Per-requester read data and ack. RAM data is valid during CAPTURE and
    // is registered on the CAPTURE -> DONE edge, the same edge that raises
    // the ack, so rdata and ack appear together in DONE.
    // -----------------------------------------------------------------------
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_req
        logic          ack_reg;
        logic [DW-1:0] rdata_reg;
        logic          owner_capture;

        assign owner_capture = (state_reg == CAPTURE) && (gnt_reg == 1'(gi));

        always_ff @(posedge clk) begin
            if (!reset) begin
                ack_reg   <= 1'b0;
                rdata_reg <= '0;
            end else begin
                ack_reg <= owner_capture;
                if (owner_capture && !we_reg) begin
                    rdata_reg <= mem_rdata;
                end
            end
        end
    end

    assign r0_ack   = g_req[0].ack_reg;
    assign r1_ack   = g_req[1].ack_reg;
    assign r0_rdata = g_req[0].rdata_reg;
    assign r1_rdata = g_req[1].rdata_reg;

endmodule

// File: tb/tb_dram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dram_arbiter
//
// Directed bench for dram_arbiter. A 256-word RAM model sits on the memory
// port. A transaction-level reference (grant time plus edges elapsed since
// the grant, and a shadow of the RAM contents) predicts every output, and a
// negedge process compares against it each cycle. Directed sequences add
// literal expectations for latency, grant order and RAM contents.
// ---------------------------------------------------------------------------
module tb_dram_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          r0_req, r0_we, r1_req, r1_we;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          r0_ack, r1_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .r0_req   (r0_req),
        .r0_we    (r0_we),
        .r0_addr  (r0_addr),
        .r0_wdata (r0_wdata),
        .r0_rdata (r0_rdata),
        .r0_ack   (r0_ack),
        .r1_req   (r1_req),
        .r1_we    (r1_we),
        .r1_addr  (r1_addr),
        .r1_wdata (r1_wdata),
        .r1_rdata (r1_rdata),
        .r1_ack   (r1_ack),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] dflt(input int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    // RAM model: word addressed by addr[9:2]; contents reload on reset.
    logic [31:0] ram [256];
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) ram[i] <= dflt(i);
            mem_rdata <= '0;
        end else begin
            if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
            mem_rdata <= ram[mem_addr[9:2]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model. A transaction is described by who was granted and
    // what it asked for; expected outputs follow from how many edges have
    // passed since the grant edge (1: strobe ends, 2: ack + data, 3: done).
    // -----------------------------------------------------------------------
    function automatic bit pick(input bit a, input bit b, input bit p);
        if (a && b) return p;
        return b;
    endfunction

    bit          model_valid = 1'b0;
    bit          m_busy, m_prio, t_g, t_we;
    int          m_n;
    logic [31:0] t_addr;
    logic [31:0] shadow [256];
    logic [1:0]  exp_ack;
    logic        exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [31:0] exp_rdata [2];
    bit          m_pick;

    assign m_pick = pick(r0_req, r1_req, m_prio);

    always @(posedge clk) begin
        if (!reset) begin
            model_valid  <= 1'b1;
            m_busy       <= 1'b0;
            m_n          <= 0;
            m_prio       <= 1'b0;
            exp_ack      <= 2'b00;
            exp_we       <= 1'b0;
            exp_addr     <= '0;
            exp_wdata    <= '0;
            exp_rdata[0] <= '0;
            exp_rdata[1] <= '0;
            for (int i = 0; i < 256; i++) shadow[i] <= dflt(i);
        end else if (!m_busy) begin
            exp_we <= 1'b0;
            if (r0_req || r1_req) begin
                m_busy    <= 1'b1;
                m_n       <= 1;
                t_g       <= m_pick;
                m_prio    <= !m_pick;
                t_we      <= m_pick ? r1_we : r0_we;
                t_addr    <= m_pick ? r1_addr : r0_addr;
                exp_we    <= m_pick ? r1_we : r0_we;
                exp_addr  <= m_pick ? r1_addr : r0_addr;
                exp_wdata <= m_pick ? r1_wdata : r0_wdata;
                if (m_pick ? r1_we : r0_we)
                    shadow[m_pick ? r1_addr[9:2] : r0_addr[9:2]] <= m_pick ? r1_wdata : r0_wdata;
            end
        end else begin
            m_n <= m_n + 1;
            if (m_n == 1) exp_we <= 1'b0;
            if (m_n == 2) begin
                exp_ack[t_g] <= 1'b1;
                if (!t_we) exp_rdata[t_g] <= shadow[t_addr[9:2]];
            end
            if (m_n == 3) begin
                exp_ack <= 2'b00;
                m_busy  <= 1'b0;
            end
        end
    end

    // Per-cycle compare plus write/ack monitors.
    int          ack_cnt0 = 0, ack_cnt1 = 0, wr_pulses = 0;
    logic [31:0] last_wr_addr = '0, last_wr_data = '0;

    always @(negedge clk) begin
        if (model_valid) begin
            chk("r0_ack", r0_ack, exp_ack[0]);
            chk("r1_ack", r1_ack, exp_ack[1]);
            chk("mem_we", mem_we, exp_we);
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_wdata", mem_wdata, exp_wdata);
            chk("r0_rdata", r0_rdata, exp_rdata[0]);
            chk("r1_rdata", r1_rdata, exp_rdata[1]);
            chk("ack_exclusive", r0_ack && r1_ack, 1'b0);
        end
        if (r0_ack) begin
            ack_cnt0 <= ack_cnt0 + 1;
            $display("txn cycle %0d: req0 ack rdata=%h", cyc, r0_rdata);
        end
        if (r1_ack) begin
            ack_cnt1 <= ack_cnt1 + 1;
            $display("txn cycle %0d: req1 ack rdata=%h", cyc, r1_rdata);
        end
        if (mem_we) begin
            wr_pulses    <= wr_pulses + 1;
            last_wr_addr <= mem_addr;
            last_wr_data <= mem_wdata;
        end
    end

    // Wait (bounded) for requester r's ack; returns the cycle and its rdata.
    task automatic wait_ack(input int r, output int at, output logic [31:0] data);
        at   = -1;
        data = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ((r == 0) ? r0_ack : r1_ack) begin
                at   = cyc;
                data = (r == 0) ? r0_rdata : r1_rdata;
                break;
            end
        end
        chk("ack_seen", at >= 0, 1'b1);
    endtask

    // Full single-requester access; req dropped right after the ack cycle.
    task automatic access(input int r, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] data);
        int at;
        if (r == 0) begin
            r0_we = we; r0_addr = addr; r0_wdata = wd; r0_req = 1'b1;
        end else begin
            r1_we = we; r1_addr = addr; r1_wdata = wd; r1_req = 1'b1;
        end
        wait_ack(r, at, data);
        @(posedge clk); #1;
        if (r == 0) r0_req = 1'b0; else r1_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          rel, at, who, a0, wp;
        logic [31:0] d;

        reset = 1'b0;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h10; r0_wdata = '0;
        r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0;    r1_wdata = '0;

        // 1. Reset held with r0 requesting; then first-access latency.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_r0_ack", r0_ack, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        reset = 1'b1;
        rel = cyc;
        wait_ack(0, at, d);
        chk("rst_latency", at - rel, 3);
        chk("rst_rd_10", d, 32'hA000_0004);
        @(posedge clk); #1; r0_req = 1'b0;

        // 2. r0 write then read-back of 0x40.
        wp = wr_pulses;
        access(0, 1'b1, 32'h40, 32'hDEAD_BEEF, d);
        chk("wr_pulses", wr_pulses - wp, 1);
        chk("wr_addr", last_wr_addr, 32'h40);
        chk("wr_data", last_wr_data, 32'hDEAD_BEEF);
        access(0, 1'b0, 32'h40, 32'h0, d);
        chk("rd_40", d, 32'hDEAD_BEEF);
        chk("r1_idle", ack_cnt1, 0);

        // 3. Simultaneous requests straight out of reset.
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        r0_we = 1'b0; r0_addr = 32'h10; r0_req = 1'b1;
        r1_we = 1'b0; r1_addr = 32'h20; r1_req = 1'b1;
        rel = cyc;
        wait_ack(0, at, d);
        chk("sim_r0_cycle", at - rel, 3);
        chk("sim_r0_data", d, 32'hA000_0004);
        @(posedge clk); #1; r0_req = 1'b0;
        wait_ack(1, at, d);
        chk("sim_r1_cycle", at - rel, 7);
        chk("sim_r1_data", d, 32'hA000_0008);
        @(posedge clk); #1; r1_req = 1'b0;

        // 4. Both requesting continuously: strict alternation from prio 0.
        r0_we = 1'b0; r0_addr = 32'h10; r0_req = 1'b1;
        r1_we = 1'b0; r1_addr = 32'h30; r1_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            who = -1;
            for (int k = 0; k < 20 && who < 0; k++) begin
                @(negedge clk);
                if (r0_ack) who = 0;
                else if (r1_ack) who = 1;
            end
            chk("fair_order", who, i % 2);
        end
        @(posedge clk); #1;
        r0_req = 1'b0; r1_req = 1'b0;

        // 5. r1 write whose fields change during ISSUE.
        r1_we = 1'b1; r1_addr = 32'h80; r1_wdata = 32'h1234; r1_req = 1'b1;
        @(posedge clk); #1;
        r1_we = 1'b0; r1_addr = 32'h84; r1_wdata = 32'hFFFF_FFFF;
        wait_ack(1, at, d);
        @(posedge clk); #1; r1_req = 1'b0;
        chk("fc_ram_80", ram[32], 32'h0000_1234);
        chk("fc_ram_84", ram[33], 32'hA000_0021);
        access(1, 1'b0, 32'h80, 32'h0, d);
        chk("fc_readback", d, 32'h0000_1234);

        // 6. Reset during CAPTURE of an r0 read; then prio must be back to 0.
        a0 = ack_cnt0;
        r0_we = 1'b0; r0_addr = 32'h44; r0_req = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("mr_r0_rdata", r0_rdata, 32'h0);
        chk("mr_r0_ack", r0_ack, 1'b0);
        chk("mr_mem_we", mem_we, 1'b0);
        r0_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("mr_no_ack", ack_cnt0 - a0, 0);
        r0_addr = 32'h48; r0_req = 1'b1;
        r1_we = 1'b0; r1_addr = 32'h4C; r1_req = 1'b1;
        who = -1;
        for (int k = 0; k < 20 && who < 0; k++) begin
            @(negedge clk);
            if (r0_ack) who = 0;
            else if (r1_ack) who = 1;
        end
        chk("mr_prio_first", who, 0);
        @(posedge clk); #1; r0_req = 1'b0;
        wait_ack(1, at, d);
        chk("mr_r1_data", d, 32'hA000_0013);
        @(posedge clk); #1; r1_req = 1'b0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
